// File: rtl/jk_pkg.sv
// jk_pkg: JK operation encoding and parameter range check shared by the JK counter blocks.
package jk_pkg;
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  // Checks that MODULUS >= 2 and fits in WIDTH bits by doubling instead of using $clog2.
  function automatic bit params_ok(input int width, input int modulus);
    int cap;
    cap = 1;
    for (int i = 0; i < width && cap < modulus; i++) cap = cap * 2;
    return (modulus >= 2) && (cap >= modulus);
  endfunction
endpackage

// File: rtl/jk_bit_cell.sv
// jk_bit_cell: one JK storage bit with async active-high reset; q and qbar are both registered.
module jk_bit_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);
  logic q_q, qbar_q, q_d;
  jk_op_e op;
  always_comb begin
    op  = jk_op_e'({j, k});
    q_d = (op == JK_TOGGLE) ? ~q_q :
          (op == JK_SET)    ? 1'b1 :
          (op == JK_RESET)  ? 1'b0 : q_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_q    <= 1'b0;
      qbar_q <= 1'b1;
    end else begin
      q_q    <= q_d;
      qbar_q <= ~q_d;
    end
  assign q    = q_q;
  assign qbar = qbar_q;
endmodule

// File: rtl/jk_sync_counter.sv
// jk_sync_counter: modulo-MODULUS up/down counter with load and clamp, stored in JK bit cells.
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);

  if (!params_ok(WIDTH, MODULUS)) begin : g_bad_params
    $error("jk_sync_counter: MODULUS must be >= 2 and fit in WIDTH bits");
  end

  logic [WIDTH-1:0] cnt_d, j, k;
  logic             in_range, din_ok;

  // Drive each cell as explicit set/reset toward the next count, so J=K=1 never occurs.
  always_comb begin
    in_range = {1'b0, q} < MOD_X;
    din_ok   = {1'b0, din} < MOD_X;
    cnt_d    = load      ? (din_ok ? din : MAX) :
               !en       ? q :
               !in_range ? '0 :
               up        ? ((q == MAX) ? '0 : q + 1'b1) :
                           ((q == '0) ? MAX : q - 1'b1);
    j        = cnt_d & ~q;
    k        = ~cnt_d & q;
    tc       = ~rst & en & ~load & ((up & (q == MAX)) | (~up & (q == '0)));
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_bit_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .j    (j[i]),
      .k    (k[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end
endmodule

// File: tb/tb_jk_sync_counter.sv
// tb_jk_sync_counter: directed vector table plus randomized run against a modulo-arithmetic model.
module tb_jk_sync_counter;
  localparam int M = 10;

  logic       clk = 1'b1;
  logic       rst, en, up, load;
  logic [3:0] din, q, qbar;
  logic       tc;
  int         errors = 0;
  int         checks = 0;
  int         m_q = 0;

  always #50 clk = ~clk;

  jk_sync_counter #(.WIDTH(4), .MODULUS(M)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .din(din), .q(q), .qbar(qbar), .tc(tc)
  );

  typedef struct {
    logic       en, up, load;
    logic [3:0] din;
    int         exp_q;
    logic       exp_tc;
  } vec_t;
  vec_t vecs[$];

  function automatic int model_next(int cur, bit e, bit u, bit l, int d);
    if (l) return (d > M - 1) ? M - 1 : d;
    if (!e) return cur;
    return u ? (cur + 1) % M : (cur + M - 1) % M;
  endfunction

  // Terminal count means the enabled step wraps around the modulus.
  function automatic bit model_tc(int cur, bit e, bit u, bit l);
    int nxt;
    nxt = u ? (cur + 1) % M : (cur + M - 1) % M;
    return e && !l && (u ? (nxt < cur) : (nxt > cur));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic invariants();
    logic [3:0] nq, jk;
    nq = ~q;
    jk = dut.j & dut.k;
    chk("qbar_inv", int'(qbar), int'(nq));
    chk("jk_excl", int'(jk), 0);
    chk("q_range", int'(q < 4'd10), 1);
  endtask

  task automatic drive(input logic e, input logic u, input logic l, input logic [3:0] d,
                       input logic exp_tc, input int exp_q);
    @(negedge clk);
    en = e; up = u; load = l; din = d;
    #1;
    chk("tc", int'(tc), int'(exp_tc));
    invariants();
    @(posedge clk);
    #1;
    m_q = model_next(m_q, e, u, l, int'(d));
    chk("q", int'(q), exp_q);
    chk("q_model", int'(q), m_q);
    invariants();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; up = 1'b0; load = 1'b0; din = '0;
    #140;
    chk("rst_q", int'(q), 0);
    chk("rst_qbar", int'(qbar), 15);
    chk("rst_tc", int'(tc), 0);
    #10;
    rst = 1'b0; en = 1'b0;
    #10;
    chk("post_rst_q", int'(q), 0);
    chk("post_rst_tc", int'(tc), 0);

    for (int i = 1; i <= 10; i++)
      vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd0, i % 10, (i == 10)});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 9, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 8, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd6, 6, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd13, 9, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 4'd3, 3, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 4, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 4, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd0, 5, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd0, 5, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd0, 4, 1'b0});
    foreach (vecs[i])
      drive(vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].din, vecs[i].exp_tc, vecs[i].exp_q);

    @(negedge clk);
    en = 1'b1; up = 1'b0; load = 1'b0;
    #20 rst = 1'b1;
    #5;
    chk("mid_rst_q", int'(q), 0);
    chk("mid_rst_qbar", int'(qbar), 15);
    chk("mid_rst_tc", int'(tc), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_q", int'(q), 0);
    @(negedge clk);
    rst = 1'b0; up = 1'b1;
    @(posedge clk);
    #1;
    m_q = 1;
    chk("first_step_q", int'(q), 1);

    for (int i = 0; i < 300; i++) begin
      logic       e, u, l;
      logic [3:0] d;
      int         exp_q;
      logic       exp_tc;
      e = ($urandom_range(0, 3) != 0);
      u = 1'($urandom_range(0, 1));
      l = ($urandom_range(0, 7) == 0);
      d = 4'($urandom_range(0, 15));
      exp_tc = model_tc(m_q, e, u, l);
      exp_q  = model_next(m_q, e, u, l, int'(d));
      drive(e, u, l, d, exp_tc, exp_q);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
